// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default stability requirement and a small state-decoding helper.
package debounce_pkg;

    localparam int STABLE_TICKS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CHK_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        CHK_RELEASE = 2'd3
    } db_state_t;

    // The accepted level only changes when a check completes, so both the
    // stable-high state and the release check report a pressed button.
    function automatic logic state_level(input db_state_t s);
        return (s == PRESSED) || (s == CHK_RELEASE);
    endfunction

endpackage

// File: rtl/btn_debounce_rise_detect.sv
// Registers a slow enable-style signal into clk_in and produces a one-cycle
// strobe the cycle after it is first sampled high following a low sample.
module rise_detect (
    input  logic clk_in,
    input  logic rst_a_p,
    input  logic sig_in,
    output logic pulse_out
);

    logic sample_reg;
    logic hist_reg;

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            sample_reg <= 1'b0;
            hist_reg   <= 1'b0;
        end else begin
            sample_reg <= sig_in;
            hist_reg   <= sample_reg;
        end
    end

    // Both operands are flops, so the strobe never depends combinationally on sig_in.
    assign pulse_out = sample_reg & ~hist_reg;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes the raw button, qualifies each new level
// over STABLE_TICKS slow ticks and reports the level plus press/release strobes.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_a_p,
    input  logic tick_clk,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

    logic sync1_reg;
    logic btn_sync;
    logic tick;

    db_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic level_reg, level_next;
    logic press_reg, press_next;
    logic release_reg, release_next;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync1_reg <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            sync1_reg <= btn_in;
            btn_sync  <= sync1_reg;
        end
    end

    rise_detect u_tick_rise (
        .clk_in    (clk_in),
        .rst_a_p   (rst_a_p),
        .sig_in    (tick_clk),
        .pulse_out (tick)
    );

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A mismatch against the candidate level is tested before the tick, so an
    // abort always wins over a coincident tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (btn_sync) begin
                    state_next = CHK_PRESS;
                end
            end
            CHK_PRESS: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            PRESSED: begin
                cnt_next = '0;
                if (!btn_sync) begin
                    state_next = CHK_RELEASE;
                end
            end
            CHK_RELEASE: begin
                if (btn_sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobes are derived from the registered level, so they line up exactly
    // with the cycle in which btn_level changes and can never coincide.
    always_comb begin
        level_next   = state_level(state_reg);
        press_next   = level_next & ~level_reg;
        release_next = ~level_next & level_reg;
    end

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized and directed stimulus for btn_debounce, checked by a scoreboard
// fed from a run-length reference model of the debouncing rules.
module tb_btn_debounce;

    localparam int N    = 4;
    localparam int MAXC = 8192;

    logic clk_in   = 1'b0;
    logic rst_a_p  = 1'b1;
    logic tick_clk = 1'b0;
    logic btn_in   = 1'b0;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    btn_debounce #(.STABLE_TICKS(N)) dut (
        .clk_in      (clk_in),
        .rst_a_p     (rst_a_p),
        .tick_clk    (tick_clk),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int lv;
        int cyc;
    } ev_t;

    bit   b_h  [MAXC];
    bit   tc_h [MAXC];
    int   exp_lv [MAXC];
    ev_t  evq[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted level plus the current run of disagreeing samples.
    int acc_lv    = 0;
    bit run_on    = 1'b0;
    int run_ticks = 0;
    int tphase    = 0;

    // Processes what the design sees in cycle n: the button delayed by the
    // two-flop synchronizer and the tick derived from tick_clk history.
    function automatic void model_cycle(input int n);
        bit  sync;
        bit  tk;
        int  prev;
        ev_t e;
        if (n < 2 || n + 2 >= MAXC) return;
        sync = b_h[n-2];
        tk   = tc_h[n-1] & ~tc_h[n-2];
        prev = acc_lv;
        if (int'(sync) != acc_lv) begin
            if (!run_on) begin
                run_on    = 1'b1;
                run_ticks = 0;
            end else if (tk) begin
                run_ticks++;
                if (run_ticks == N) begin
                    acc_lv = int'(sync);
                    run_on = 1'b0;
                end
            end
        end else begin
            run_on = 1'b0;
        end
        exp_lv[n+2] = acc_lv;
        if (acc_lv != prev) begin
            e.lv  = acc_lv;
            e.cyc = n + 2;
            evq.push_back(e);
        end
    endfunction

    task automatic step(input bit b, input bit tc);
        @(posedge clk_in);
        #1;
        btn_in   = b;
        tick_clk = tc;
        if (cyc < MAXC) begin
            b_h[cyc]  = b;
            tc_h[cyc] = tc;
        end
        model_cycle(cyc);
    endtask

    task automatic hold(input bit b, input int len);
        for (int i = 0; i < len; i++) begin
            step(b, ((tphase % 10) >= 5));
            tphase++;
        end
    endtask

    task automatic release_reset();
        int r;
        @(negedge clk_in);
        #2;
        rst_a_p = 1'b0;
        r = cyc;
        b_h[r]  = btn_in;
        tc_h[r] = tick_clk;
        if (r >= 1) begin b_h[r-1] = 1'b0; tc_h[r-1] = 1'b0; end
        if (r >= 2) begin b_h[r-2] = 1'b0; tc_h[r-2] = 1'b0; end
        acc_lv    = 0;
        run_on    = 1'b0;
        exp_lv[r]   = 0;
        exp_lv[r+1] = 0;
        model_cycle(r);
    endtask

    task automatic pulse_reset();
        #2 rst_a_p = 1'b1;
        #1;
        n_vec++;
        if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: outputs level/press/release=%b required=000",
                     {btn_level, btn_press, btn_release});
        end
        evq.delete();
        acc_lv = 0;
        run_on = 1'b0;
        repeat (2) @(posedge clk_in);
        release_reset();
    endtask

    // Monitor: checks the level every cycle and pops one expected event per strobe.
    initial begin : monitor
        int  c;
        ev_t e;
        forever begin
            @(negedge clk_in);
            c = cyc;
            if (!rst_a_p && c < MAXC) begin
                if (exp_lv[c] >= 0) begin
                    n_vec++;
                    if (btn_level !== (exp_lv[c] != 0)) begin
                        n_err++;
                        $display("FAIL level: cycle %0d got %b required %0d", c, btn_level, exp_lv[c]);
                    end
                end
                while (evq.size() > 0 && evq[0].cyc < c) begin
                    e = evq.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL missed_pulse: cycle %0d got none required %s",
                             e.cyc, (e.lv != 0) ? "press" : "release");
                end
                if (btn_press || btn_release) begin
                    n_vec++;
                    if (btn_press && btn_release) begin
                        n_err++;
                        $display("FAIL both_strobes: cycle %0d got press=1 release=1 required at most one", c);
                    end else if (evq.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse: cycle %0d got press=%b release=%b required none",
                                 c, btn_press, btn_release);
                    end else begin
                        e = evq.pop_front();
                        if (e.cyc != c || (e.lv != 0) != btn_press) begin
                            n_err++;
                            $display("FAIL pulse: cycle %0d got press=%b release=%b required %s at cycle %0d",
                                     c, btn_press, btn_release, (e.lv != 0) ? "press" : "release", e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < MAXC; i++) exp_lv[i] = -1;
        #2;
        n_vec++;
        if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_state: outputs=%b required=000", {btn_level, btn_press, btn_release});
        end
        repeat (3) @(posedge clk_in);
        release_reset();

        // Clean press held 100 cycles, then clean release.
        hold(1'b0, 20);
        hold(1'b1, 100);
        hold(1'b0, 100);

        // Bounce every 7 cycles for 60 cycles, then hold pressed.
        for (int k = 0; k < 60; k++) hold(((k / 7) % 2) == 0, 1);
        hold(1'b1, 80);
        hold(1'b0, 80);

        // Short 25-cycle dropout while pressed must not release.
        hold(1'b1, 80);
        hold(1'b0, 25);
        hold(1'b1, 60);
        hold(1'b0, 80);

        // Abort coinciding with a tick in CHK_PRESS after two counted ticks.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(k < 12, (k == 4) || (k == 5) || (k == 8) || (k == 9) || (k >= 13));
            if (k == 14 || k == 15) begin
                @(negedge clk_in);
                n_vec++;
                if (int'(dut.cnt_reg) != ((k == 14) ? 2 : 0)) begin
                    n_err++;
                    $display("FAIL abort_counter: step %0d got %0d required %0d",
                             k, dut.cnt_reg, (k == 14) ? 2 : 0);
                end
            end
        end
        hold(1'b0, 40);

        // Reset in the middle of a release check, then in the pressed state.
        hold(1'b1, 80);
        hold(1'b0, 15);
        pulse_reset();
        hold(1'b0, 60);
        hold(1'b1, 80);
        pulse_reset();
        hold(1'b1, 80);
        hold(1'b0, 80);

        // tick_clk stuck high: no ticks, so a held button is never accepted.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 200; k++) step(1'b1, 1'b1);
        @(negedge clk_in);
        n_vec++;
        if (btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_tick: got level %b required 0", btn_level);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
        hold(1'b0, 40);

        // Randomized button activity.
        for (int s = 0; s < 30; s++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 60));
        end
        hold(1'b0, 80);
        hold(1'b0, 5);

        n_vec++;
        if (evq.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: got %0d outstanding required 0", evq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
